// File: rtl/cache_port_arbiter_if.sv
// Bus bundle between requesters, the round-robin port arbiter and the cache core.
// ARB_LOCK_EN adds the per-requester req_lock input.
interface cache_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ-1:0]              req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata;
  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb;
`ifdef ARB_LOCK_EN
  logic [NUM_REQ-1:0]              req_lock;
`endif
  logic [NUM_REQ-1:0]              rsp_valid;
  logic [DATA_WIDTH-1:0]           rsp_rdata;
  logic                            cache_req_valid;
  logic                            cache_req_ready;
  logic                            cache_req_we;
  logic [ADDR_WIDTH-1:0]           cache_req_addr;
  logic [DATA_WIDTH-1:0]           cache_req_wdata;
  logic [DATA_WIDTH/8-1:0]         cache_req_wstrb;
  logic                            cache_rsp_valid;
  logic [DATA_WIDTH-1:0]           cache_rsp_rdata;

  // Arbiter side.
  modport slave (
`ifdef ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata,
    output cache_req_valid, cache_req_we, cache_req_addr, cache_req_wdata, cache_req_wstrb,
    input  cache_req_ready, cache_rsp_valid, cache_rsp_rdata
  );

  // Environment side: requesters plus cache core.
  modport master (
`ifdef ARB_LOCK_EN
    output req_lock,
`endif
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata,
    input  cache_req_valid, cache_req_we, cache_req_addr, cache_req_wdata, cache_req_wstrb,
    output cache_req_ready, cache_rsp_valid, cache_rsp_rdata
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing the single cache core port among NUM_REQ requesters,
// one transaction outstanding. Optional requester lock under `ifdef ARB_LOCK_EN.
module cache_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
) (
  input  logic                ACLK,
  input  logic                ARESET,
  cache_port_arbiter_if.slave bus,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                busy
);
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] winner;
  logic [ID_WIDTH-1:0] next_ptr;
  logic [ID_WIDTH-1:0] idx_w;
  logic [NUM_REQ-1:0]  req_mask;
  logic                any_req;
  int                  idx;

`ifdef ARB_LOCK_EN
  localparam logic [3:0] LOCK_TMO = 4'd15;
  logic                locked;
  logic                lock_cap;
  logic [3:0]          idle_cnt;
  logic [ID_WIDTH-1:0] lock_id;

  // While locked only the owner is eligible; rr_ptr is frozen so the search still finds it.
  always_comb begin
    req_mask = bus.req_valid;
    if (locked) req_mask = bus.req_valid & (NUM_REQ'(1) << lock_id);
  end
`else
  assign req_mask = bus.req_valid;
`endif

  // First set bit at or above rr_ptr, modulo NUM_REQ; descending scan so the nearest wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = ID_WIDTH'(idx);
      if (req_mask[idx_w]) begin
        winner  = idx_w;
        any_req = 1'b1;
      end
    end
  end

  assign next_ptr = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign busy     = (state != IDLE);

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && any_req && !ARESET) bus.req_ready[winner] = 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      grant_id            <= '0;
      bus.cache_req_valid <= 1'b0;
      bus.cache_req_we    <= 1'b0;
      bus.cache_req_addr  <= '0;
      bus.cache_req_wdata <= '0;
      bus.cache_req_wstrb <= '0;
      bus.rsp_valid       <= '0;
      bus.rsp_rdata       <= '0;
`ifdef ARB_LOCK_EN
      locked   <= 1'b0;
      lock_cap <= 1'b0;
      lock_id  <= '0;
      idle_cnt <= '0;
`endif
    end else begin
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id            <= winner;
            bus.cache_req_valid <= 1'b1;
            bus.cache_req_we    <= bus.req_we[winner];
            bus.cache_req_addr  <= bus.req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
            bus.cache_req_wdata <= bus.req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
            bus.cache_req_wstrb <= bus.req_wstrb[winner*SW +: SW];
            state               <= ISSUE;
`ifdef ARB_LOCK_EN
            lock_cap <= bus.req_lock[winner];
            idle_cnt <= '0;
          end else if (locked) begin
            // Owner silent for 16 IDLE cycles: drop the lock so others are not starved.
            if (idle_cnt == LOCK_TMO) begin
              locked   <= 1'b0;
              rr_ptr   <= next_ptr;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
`endif
          end
        end
        ISSUE: begin
          if (bus.cache_req_ready) begin
            bus.cache_req_valid <= 1'b0;
            state               <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (bus.cache_rsp_valid) begin
            bus.rsp_valid[grant_id] <= 1'b1;
            bus.rsp_rdata           <= bus.cache_rsp_rdata;
            state                   <= IDLE;
`ifdef ARB_LOCK_EN
            locked   <= lock_cap;
            lock_id  <= grant_id;
            idle_cnt <= '0;
            if (!lock_cap) rr_ptr <= next_ptr;
`else
            rr_ptr <= next_ptr;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter (NUM_REQ=3): requester drivers and a cache
// model generate traffic, a negedge monitor pops hand-written expectations.
module tb_cache_port_arbiter;
  localparam int NR = 3;

  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  logic [1:0] grant_id;
  logic       busy;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         lat = 0;
  int         grant_cyc [NR];
  int         rsp_cyc [NR];
  bit         chk_next = 1'b0;

  typedef struct packed {
    logic        lock;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  id;
  } cache_exp_t;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] rdata;
  } rsp_exp_t;

  int         exp_grant[$];
  cache_exp_t exp_cache[$];
  rsp_exp_t   exp_rsp[$];

  cache_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  cache_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(2)) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .bus      (bus.slave),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Requester drivers: hold valid and payload until req_ready, then load the next item.
  for (genvar g = 0; g < NR; g++) begin : rqg
    txn_t q[$];
    txn_t cur;
    logic v;
    assign bus.req_valid[g]         = v;
    assign bus.req_we[g]            = cur.we;
    assign bus.req_addr[g*32 +: 32]  = cur.addr;
    assign bus.req_wdata[g*32 +: 32] = cur.wdata;
    assign bus.req_wstrb[g*4 +: 4]   = cur.wstrb;
`ifdef ARB_LOCK_EN
    assign bus.req_lock[g]          = cur.lock;
`endif
    initial begin
      bit done;
      v   = 1'b0;
      cur = '0;
      forever begin
        @(negedge ACLK);
        done = v && bus.req_ready[g];
        @(posedge ACLK);
        #1;
        if (done) v = 1'b0;
        if (!v && q.size() != 0) begin
          cur = q.pop_front();
          v   = 1'b1;
        end
      end
    end
  end

  // Cache core model: answers each accepted request after lat extra cycles.
  initial begin
    logic [31:0] a;
    int          l;
    bus.cache_req_ready = 1'b1;
    bus.cache_rsp_valid = 1'b0;
    bus.cache_rsp_rdata = '0;
    forever begin
      @(negedge ACLK);
      if (bus.cache_req_valid && bus.cache_req_ready) begin
        a = bus.cache_req_addr;
        l = lat;
        @(posedge ACLK);
        repeat (l) @(posedge ACLK);
        #1;
        bus.cache_rsp_valid = 1'b1;
        bus.cache_rsp_rdata = {16'hDEAD, a[15:0]};
        @(posedge ACLK);
        #1;
        bus.cache_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    cache_exp_t ce;
    rsp_exp_t   re;
    forever begin
      @(negedge ACLK);
      if (chk_next) check("req_to_cache_lat", bus.cache_req_valid, 1'b1);
      chk_next = (bus.req_ready != 0);
      for (int i = 0; i < NR; i++) begin
        if (bus.req_ready[i]) begin
          grant_cyc[i] = cyc;
          if (exp_grant.size() == 0) fail_now("unexpected_grant");
          else check("grant_order", i, exp_grant.pop_front());
        end
      end
      if (bus.cache_req_valid && bus.cache_req_ready) begin
        if (exp_cache.size() == 0) fail_now("unexpected_cache_req");
        else begin
          ce = exp_cache.pop_front();
          check("cache_we", bus.cache_req_we, ce.we);
          check("cache_addr", bus.cache_req_addr, ce.addr);
          check("cache_wdata", bus.cache_req_wdata, ce.wdata);
          check("cache_wstrb", bus.cache_req_wstrb, ce.wstrb);
          check("grant_id", grant_id, ce.id);
        end
      end
      if (bus.rsp_valid != 0) begin
        for (int i = 0; i < NR; i++) if (bus.rsp_valid[i]) rsp_cyc[i] = cyc;
        if (exp_rsp.size() == 0) fail_now("unexpected_rsp");
        else begin
          re = exp_rsp.pop_front();
          check("rsp_route", bus.rsp_valid, 3'b001 << re.idx);
          check("rsp_rdata", bus.rsp_rdata, re.rdata);
        end
      end
    end
  end

  task automatic push_req(input int g, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input logic lk);
    txn_t t;
    t = '{lock: lk, we: we, addr: a, wdata: d, wstrb: s};
    case (g)
      0:       rqg[0].q.push_back(t);
      1:       rqg[1].q.push_back(t);
      default: rqg[2].q.push_back(t);
    endcase
  endtask

  task automatic expect_tx(input int id, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input logic [31:0] rd, input bit has_rsp);
    exp_grant.push_back(id);
    exp_cache.push_back('{we: we, addr: a, wdata: d, wstrb: s, id: 2'(id)});
    if (has_rsp) exp_rsp.push_back('{idx: 2'(id), rdata: rd});
  endtask

  function automatic bit pending();
    return exp_grant.size() != 0 || exp_cache.size() != 0 || exp_rsp.size() != 0 ||
           rqg[0].q.size() != 0 || rqg[1].q.size() != 0 || rqg[2].q.size() != 0 ||
           rqg[0].v || rqg[1].v || rqg[2].v;
  endfunction

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while (pending() && c < maxc) begin
      @(negedge ACLK);
      c++;
    end
    if (pending()) begin
      fail_now("drain_timeout");
      exp_grant.delete();
      exp_cache.delete();
      exp_rsp.delete();
    end
    repeat (3) @(negedge ACLK);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c;
    // Reset state.
    repeat (2) @(negedge ACLK);
    check("rst_req_ready", bus.req_ready, 3'b000);
    check("rst_rsp_valid", bus.rsp_valid, 3'b000);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_cache_valid", bus.cache_req_valid, 1'b0);
    check("rst_cache_we", bus.cache_req_we, 1'b0);
    check("rst_cache_addr", bus.cache_req_addr, 32'h0);
    check("rst_cache_wdata", bus.cache_req_wdata, 32'h0);
    check("rst_cache_wstrb", bus.cache_req_wstrb, 4'h0);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_busy", busy, 1'b0);
    ARESET = 1'b0;
    @(negedge ACLK);

    // Single write from req0.
    push_req(0, 1'b1, 32'h0, 32'h1, 4'hF, 1'b0);
    expect_tx(0, 1'b1, 32'h0, 32'h1, 4'hF, 32'hDEAD0000, 1'b1);
    drain(50);
    check("busy_after_write", busy, 1'b0);

    // req0/req1 reads; rr_ptr=1 after the write, so order is 1,0,1,0.
    push_req(0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
    push_req(0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
    push_req(1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
    push_req(1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
    expect_tx(1, 1'b0, 32'h8, 32'h0, 4'h0, 32'hDEAD0008, 1'b1);
    expect_tx(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'hDEAD0004, 1'b1);
    expect_tx(1, 1'b0, 32'h8, 32'h0, 4'h0, 32'hDEAD0008, 1'b1);
    expect_tx(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'hDEAD0004, 1'b1);
    drain(100);

    // All three valid (rr_ptr=1): 1,2,0,1,2,0 wraps at 3; then req2 alone.
    for (int r = 0; r < 2; r++)
      for (int g = 0; g < NR; g++) push_req(g, 1'b0, 32'h100 + 32'(16*g + 4*r), 32'h0, 4'h0, 1'b0);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NR; k++) begin
        int g;
        g = (k + 1) % NR;
        expect_tx(g, 1'b0, 32'h100 + 32'(16*g + 4*r), 32'h0, 4'h0,
                  32'hDEAD0100 + 32'(16*g + 4*r), 1'b1);
      end
    for (int r = 0; r < 3; r++) begin
      push_req(2, 1'b1, 32'h200 + 32'(r), 32'hA0 + 32'(r), 4'h1, 1'b0);
      expect_tx(2, 1'b1, 32'h200 + 32'(r), 32'hA0 + 32'(r), 4'h1, 32'hDEAD0200 + 32'(r), 1'b1);
    end
    drain(200);

    // Cache stalls 5 cycles; payload must stay put and req1 must not be granted meanwhile.
    bus.cache_req_ready = 1'b0;
    push_req(0, 1'b1, 32'h20, 32'h55, 4'h3, 1'b0);
    push_req(1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0);
    expect_tx(0, 1'b1, 32'h20, 32'h55, 4'h3, 32'hDEAD0020, 1'b1);
    expect_tx(1, 1'b0, 32'h24, 32'h0, 4'h0, 32'hDEAD0024, 1'b1);
    c = 0;
    while (!bus.cache_req_valid && c < 20) begin
      @(negedge ACLK);
      c++;
    end
    if (!bus.cache_req_valid) fail_now("stall_no_cache_req");
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("stall_valid", bus.cache_req_valid, 1'b1);
      check("stall_addr", bus.cache_req_addr, 32'h20);
      check("stall_wdata", bus.cache_req_wdata, 32'h55);
      check("stall_req_ready", bus.req_ready, 3'b000);
    end
    @(posedge ACLK);
    #1;
    bus.cache_req_ready = 1'b1;
    drain(100);

    // Reset during WAIT_RSP: the late cache response must not surface.
    lat = 4;
    push_req(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
    expect_tx(0, 1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0);
    c = 0;
    while (!(busy && !bus.cache_req_valid) && c < 20) begin
      @(negedge ACLK);
      c++;
    end
    if (!busy) fail_now("reset_no_wait_rsp");
    @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rsp_valid", bus.rsp_valid, 3'b000);
    check("midrst_cache_valid", bus.cache_req_valid, 1'b0);
    repeat (10) @(negedge ACLK);
    lat = 0;
    // rr_ptr back at 0, so req1 beats req2.
    push_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    push_req(2, 1'b0, 32'h50, 32'h0, 4'h0, 1'b0);
    expect_tx(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD0040, 1'b1);
    expect_tx(2, 1'b0, 32'h50, 32'h0, 4'h0, 32'hDEAD0050, 1'b1);
    drain(100);

`ifdef ARB_LOCK_EN
    // req0 locked twice then unlocks; req1 waits throughout.
    push_req(0, 1'b0, 32'h60, 32'h0, 4'h0, 1'b1);
    push_req(0, 1'b0, 32'h64, 32'h0, 4'h0, 1'b1);
    push_req(0, 1'b0, 32'h68, 32'h0, 4'h0, 1'b0);
    push_req(1, 1'b0, 32'h70, 32'h0, 4'h0, 1'b0);
    expect_tx(0, 1'b0, 32'h60, 32'h0, 4'h0, 32'hDEAD0060, 1'b1);
    expect_tx(0, 1'b0, 32'h64, 32'h0, 4'h0, 32'hDEAD0064, 1'b1);
    expect_tx(0, 1'b0, 32'h68, 32'h0, 4'h0, 32'hDEAD0068, 1'b1);
    expect_tx(1, 1'b0, 32'h70, 32'h0, 4'h0, 32'hDEAD0070, 1'b1);
    drain(100);
    // req0 keeps the lock then goes quiet; req1 gets in after the 16-cycle timeout.
    push_req(0, 1'b0, 32'h80, 32'h0, 4'h0, 1'b1);
    push_req(1, 1'b0, 32'h84, 32'h0, 4'h0, 1'b0);
    expect_tx(0, 1'b0, 32'h80, 32'h0, 4'h0, 32'hDEAD0080, 1'b1);
    expect_tx(1, 1'b0, 32'h84, 32'h0, 4'h0, 32'hDEAD0084, 1'b1);
    drain(100);
    check("lock_timeout_gap", grant_cyc[1] - rsp_cyc[0], 16);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
